// File: rtl/mem_ctrl.sv
// mem_ctrl: memory controller between the CPU core and a byte-wide external RAM.
// It arbitrates the instruction-fetch port against the data (load/store) port,
// with the data port taking priority. Each 32-bit access becomes four byte
// accesses, and the assembled word is returned with a one-cycle done pulse.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   if_ce_i, if_addr_i       fetch request and byte address
//   if_data_o, if_done_o     fetched word (little-endian) and completion pulse
//   mem_ce_i, mem_we_i       data request; we = 1 for a store, 0 for a load
//   mem_addr_i, mem_data_i   data byte address and store word
//   mem_sel_i                store byte enables (bit k -> bits [8k+7:8k])
//   mem_data_o, mem_done_o   loaded word (little-endian) and completion pulse
//   stallreq_o               pipeline stall while any request is outstanding
//   ram_din_i                RAM read data, valid one cycle after ram_a_o
//   ram_dout_o, ram_a_o      RAM write data and byte address
//   ram_wr_o                 RAM write strobe
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_data_i,
  input  logic [3:0]        mem_sel_i,
  output logic [31:0]       mem_data_o,
  output logic              mem_done_o,
  output logic              stallreq_o,
  input  logic [7:0]        ram_din_i,
  output logic [7:0]        ram_dout_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_wr_o
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic              own_mem;   // 1: data port owns the access, 0: fetch port
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata;
  logic [3:0]        sel;
  logic [23:0]       rbuf;      // low three bytes of a read in progress

  // Only the low ADDR_W address bits reach the RAM.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};

  // Control: state, counter, owner, done pulses and the visible data words.
  // The visible word is written only on entry to DONE, so it holds its old
  // value for the whole read rather than filling byte by byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      own_mem    <= 1'b0;
      if_data_o  <= 32'd0;
      mem_data_o <= 32'd0;
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
    end else begin
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 3'd0;
          if (mem_ce_i) begin
            own_mem <= 1'b1;
            state   <= mem_we_i ? WR : RD;
          end else if (if_ce_i) begin
            own_mem <= 1'b0;
            state   <= RD;
          end
        end
        RD: begin
          if (cnt == 3'd4) begin
            state <= DONE;
            if (own_mem) begin
              mem_data_o <= {ram_din_i, rbuf};
              mem_done_o <= 1'b1;
            end else begin
              if_data_o <= {ram_din_i, rbuf};
              if_done_o <= 1'b1;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        WR: begin
          if (cnt == 3'd3) begin
            state      <= DONE;
            mem_done_o <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: request latches and read byte capture. Latching on every IDLE
  // cycle is harmless because the values are only used after acceptance.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      base  <= mem_ce_i ? mem_addr_i[ADDR_W-1:0] : if_addr_i[ADDR_W-1:0];
      wdata <= mem_data_i;
      sel   <= mem_sel_i;
    end
    if (state == RD) begin
      case (cnt)
        3'd1:    rbuf[7:0]   <= ram_din_i;
        3'd2:    rbuf[15:8]  <= ram_din_i;
        3'd3:    rbuf[23:16] <= ram_din_i;
        default: ;
      endcase
    end
  end

  // RAM drive decoded from registered state, so reset clears it at once.
  always_comb begin
    ram_a_o    = '0;
    ram_dout_o = 8'd0;
    ram_wr_o   = 1'b0;
    case (state)
      RD: ram_a_o = base + {{(ADDR_W-3){1'b0}}, cnt};
      WR: begin
        ram_a_o  = base + {{(ADDR_W-3){1'b0}}, cnt};
        ram_wr_o = sel[cnt[1:0]];
        case (cnt[1:0])
          2'd0:    ram_dout_o = wdata[7:0];
          2'd1:    ram_dout_o = wdata[15:8];
          2'd2:    ram_dout_o = wdata[23:16];
          default: ram_dout_o = wdata[31:24];
        endcase
      end
      default: ;
    endcase
  end

  assign stallreq_o = (if_ce_i & ~if_done_o) | (mem_ce_i & ~mem_done_o);

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
  localparam int AW  = 17;
  localparam int MSK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_ce_i;
  logic [31:0]   if_addr_i;
  logic [31:0]   if_data_o;
  logic          if_done_o;
  logic          mem_ce_i;
  logic          mem_we_i;
  logic [31:0]   mem_addr_i;
  logic [31:0]   mem_data_i;
  logic [3:0]    mem_sel_i;
  logic [31:0]   mem_data_o;
  logic          mem_done_o;
  logic          stallreq_o;
  logic [7:0]    ram_din_i;
  logic [7:0]    ram_dout_o;
  logic [AW-1:0] ram_a_o;
  logic          ram_wr_o;

  logic [7:0] ram     [0:MSK];   // external RAM seen by the DUT
  logic [7:0] ref_mem [0:MSK];   // reference image of what RAM should hold

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] seen_a  [0:3];
  logic          seen_wr [0:3];
  logic [7:0]    seen_d  [0:3];
  int            lat;
  logic          stall_at_done;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .mem_sel_i(mem_sel_i), .mem_data_o(mem_data_o),
    .mem_done_o(mem_done_o), .stallreq_o(stallreq_o),
    .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o), .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o)
  );

  always #5 clk = ~clk;

  // Byte RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_wr_o) ram[ram_a_o] <= ram_dout_o;
    ram_din_i <= ram[ram_a_o];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] wrap(input logic [31:0] a, input int k);
    return AW'((a + 32'(k)) & MSK);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[wrap(a, k)];
    return w;
  endfunction

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      ram[wrap(a, k)]     = w[8*k +: 8];
      ref_mem[wrap(a, k)] = w[8*k +: 8];
    end
  endtask

  // One complete access through a single port, checked against the model.
  task automatic run(input string tag, input bit is_mem, input bit we,
                     input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd);
    int n;
    bit done;
    bit store;
    logic [31:0] prev_if, prev_mem, exp_w;
    store = is_mem && we;
    exp_w = ref_word(a);
    @(negedge clk);
    prev_if  = if_data_o;
    prev_mem = mem_data_o;
    if (is_mem) begin
      mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = a; mem_data_i = d; mem_sel_i = s;
    end else begin
      if_ce_i = 1'b1; if_addr_i = a;
    end
    n = 0;
    done = 1'b0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
      if (n <= 4) begin
        seen_a[n-1] = ram_a_o; seen_wr[n-1] = ram_wr_o; seen_d[n-1] = ram_dout_o;
      end
      done = is_mem ? mem_done_o : if_done_o;
    end
    lat = done ? n : 99;
    stall_at_done = stallreq_o;
    rd = is_mem ? mem_data_o : if_data_o;
    chk({tag, "_lat"}, lat, store ? 5 : 6);
    chk({tag, "_stall"}, stall_at_done, 0);
    chk({tag, "_wr_done"}, {ram_wr_o, 32'(ram_a_o)}, 0);
    chk({tag, "_other_done"}, is_mem ? if_done_o : mem_done_o, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_a%0d", tag, k), seen_a[k], wrap(a, k));
      chk($sformatf("%s_wr%0d", tag, k), seen_wr[k], store ? s[k] : 1'b0);
      if (store && s[k]) chk($sformatf("%s_d%0d", tag, k), seen_d[k], d[8*k +: 8]);
    end
    if (store) begin
      for (int k = 0; k < 4; k++) if (s[k]) ref_mem[wrap(a, k)] = d[8*k +: 8];
      chk({tag, "_hold_mem"}, mem_data_o, prev_mem);
      chk({tag, "_hold_if"}, if_data_o, prev_if);
    end else begin
      chk({tag, "_data"}, rd, exp_w);
      chk({tag, "_hold"}, is_mem ? if_data_o : mem_data_o, is_mem ? prev_if : prev_mem);
    end
    mem_ce_i = 1'b0;
    if_ce_i  = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, r, a, d;
    logic [7:0]  b;
    int n, mdone_at, idone_at, nwr, ndone;
    bit stall_ok;
    logic [31:0] mdata, idata;
    logic stall_last;

    rst = 1'b1;
    if_ce_i = 0; if_addr_i = 0; mem_ce_i = 0; mem_we_i = 0;
    mem_addr_i = 0; mem_data_i = 0; mem_sel_i = 0;
    for (int i = 0; i <= MSK; i++) begin
      r = $urandom; b = r[7:0]; ram[i] = b; ref_mem[i] = b;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_if_data", if_data_o, 0);
    chk("rst_mem_data", mem_data_o, 0);
    chk("rst_done", {if_done_o, mem_done_o}, 0);
    chk("rst_ram", {ram_wr_o, ram_dout_o, 32'(ram_a_o)}, 0);
    chk("rst_stall", stallreq_o, 0);
    rst = 1'b0;

    // Fetch at 0x100
    put_word(32'h100, 32'h00100513);
    run("fetch100", 0, 0, 32'h100, 0, 0, rd);
    chk("fetch100_lit", rd, 32'h00100513);

    // Byte store, sel 0010
    run("bstore", 1, 1, 32'h200, 32'hAABBCCDD, 4'b0010, rd);
    nwr = 0;
    for (int k = 0; k < 4; k++) nwr += int'(seen_wr[k]);
    chk("bstore_nwr", nwr, 1);
    chk("bstore_lit", {seen_a[1], seen_d[1]}, {17'h201, 8'hCC});

    // Word store then load
    run("wstore", 1, 1, 32'h300, 32'h12345678, 4'b1111, rd);
    chk("wstore_lit", {seen_d[0], seen_d[1], seen_d[2], seen_d[3]}, 32'h78563412);
    run("wload", 1, 0, 32'h300, 0, 0, rd);
    chk("wload_lit", rd, 32'h12345678);

    // Simultaneous requests: data port first, fetch after one IDLE cycle
    put_word(32'h10, 32'hDEADBEEF);
    put_word(32'h0, 32'h00000013);
    @(negedge clk);
    mem_ce_i = 1; mem_we_i = 0; mem_addr_i = 32'h10; if_ce_i = 1; if_addr_i = 32'h0;
    n = 0; mdone_at = -1; idone_at = -1; stall_ok = 1; stall_last = 1'b1;
    mdata = 0; idata = 0;
    while (idone_at < 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (if_done_o) begin
        idone_at = n; idata = if_data_o; stall_last = stallreq_o;
      end else if (!stallreq_o) stall_ok = 0;
      if (mem_done_o) begin
        mdone_at = n; mdata = mem_data_o; mem_ce_i = 0;
      end
    end
    if_ce_i = 0;
    chk("dual_mem_lat", mdone_at, 6);
    chk("dual_if_lat", idone_at, 13);
    chk("dual_mem_data", mdata, 32'hDEADBEEF);
    chk("dual_if_data", idata, 32'h00000013);
    chk("dual_stall_hold", stall_ok, 1);
    chk("dual_stall_end", stall_last, 0);

    // Fetch across the top of the address space; upper bits ignored
    run("wrapf", 0, 0, 32'hABC1FFFE, 0, 0, rd);
    chk("wrapf_lit", {15'd0, seen_a[0], 15'd0, seen_a[1]}, {32'h1FFFE, 32'h1FFFF});
    chk("wrapf_lit2", {15'd0, seen_a[2], 15'd0, seen_a[3]}, {32'h0, 32'h1});

    // Reset in the middle of a store (cnt = 1)
    @(negedge clk);
    mem_ce_i = 1; mem_we_i = 1; mem_addr_i = 32'h400; mem_data_i = 32'hA1B2C3D4; mem_sel_i = 4'hF;
    @(negedge clk);
    chk("rwr_c0", {ram_wr_o, 32'(ram_a_o)}, {1'b1, 32'h400});
    @(negedge clk);
    chk("rwr_c1", {ram_wr_o, 32'(ram_a_o)}, {1'b1, 32'h401});
    #1 rst = 1'b1; mem_ce_i = 0;
    #1;
    chk("rwr_wr", ram_wr_o, 0);
    chk("rwr_ram", {ram_dout_o, 32'(ram_a_o)}, 0);
    chk("rwr_data", {if_data_o, mem_data_o}, 0);
    chk("rwr_done", {if_done_o, mem_done_o, stallreq_o}, 0);
    ref_mem[17'h400] = 8'hD4;   // only byte 0 reached the RAM
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      ndone += int'(if_done_o) + int'(mem_done_o);
    end
    chk("rwr_nodone", ndone, 0);
    run("rwr_fetch", 0, 0, 32'h400, 0, 0, rd);

    // Randomized traffic against the reference model
    for (int t = 0; t < 60; t++) begin
      bit im, w;
      logic [3:0] s;
      r = $urandom; im = r[0] | r[1]; w = r[2];
      a = $urandom;
      a[16:0] = (r[3] ? 17'h1FFF0 : 17'h00500) + 17'($urandom_range(0, 24));
      d = $urandom;
      r = $urandom; s = r[3:0];
      run($sformatf("rnd%0d", t), im, w, a, d, s, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the CPU core and the single byte-wide external RAM. It arbitrates the core's instruction-fetch port and data (load/store) port, and serialises each 32-bit access into four byte accesses. It returns assembled words with a one-cycle done pulse. It drives the stall request that freezes the pipeline while an access is outstanding.

## Interface
- ADDR_W, 17, external RAM byte-address width
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_ce_i  in  1  instruction fetch request
- if_addr_i  in  32  fetch byte address
- if_data_o  out  32  fetched word, little-endian
- if_done_o  out  1  fetch complete, one-cycle pulse
- mem_ce_i  in  1  data access request
- mem_we_i  in  1  1 = store, 0 = load
- mem_addr_i  in  32  data byte address
- mem_data_i  in  32  store data
- mem_sel_i  in  4  store byte enables; bit k enables byte k (bits [8k+7:8k])
- mem_data_o  out  32  loaded word, little-endian
- mem_done_o  out  1  data access complete, one-cycle pulse
- stallreq_o  out  1  pipeline stall request
- ram_din_i  in  8  RAM read data; one-cycle read latency
- ram_dout_o  out  8  RAM write data
- ram_a_o  out  ADDR_W  RAM byte address
- ram_wr_o  out  1  RAM write strobe (1 = write this cycle)

## Operation
- States: IDLE, RD, WR, DONE. A 3-bit counter cnt, a latched base address, a latched store word, a latched sel, and an owner flag (IF or MEM).
- IDLE: at a clock edge, the controller samples the request ports.
  - mem_ce_i has priority over if_ce_i.
  - On acceptance it latches the owner, addr[ADDR_W-1:0], mem_data_i and mem_sel_i, and sets cnt = 0.
  - Next state is WR if owner = MEM and mem_we_i = 1; otherwise RD.
- RD, cnt = k, k = 0..4:
  - For k < 4: ram_a_o = base + k and ram_wr_o = 0.
  - For k ≥ 1: at the edge, capture ram_din_i into byte k-1 of the owner's data register.
  - At k = 4, go to DONE; ram_a_o and ram_wr_o are then don't-care, driven as base + 4 and 0.
- WR, cnt = k, k = 0..3:
  - ram_a_o = base + k, ram_dout_o = store byte k, ram_wr_o = sel[k].
  - After k = 3, go to DONE.
  - sel = 0000 still takes 4 cycles, with no strobes.
- DONE: the owner's done output is 1 for exactly this cycle; next state is IDLE.
  - For stores, mem_data_o is unchanged.
  - if_data_o and mem_data_o hold their value until the owner's next read completes.
- Address arithmetic is modulo 2^ADDR_W; the upper 32-ADDR_W address bits are ignored.
- stallreq_o = (if_ce_i & ~if_done_o) | (mem_ce_i & ~mem_done_o), combinational.
- Requester contract:
  - Hold ce, addr, we, data and sel stable until done is seen.
  - In the cycle after done, deassert the request or present a new one. IDLE samples in that cycle, so no access repeats.
- A requester dropping ce mid-transaction (flush) does not abort it. The access completes, done pulses, and the requester ignores it.
- Outside RD/WR: ram_a_o = 0, ram_dout_o = 0, ram_wr_o = 0.

## Timing
- Reset values: state IDLE, cnt 0, if_data_o 0, mem_data_o 0, if_done_o 0, mem_done_o 0, ram_a_o 0, ram_dout_o 0, ram_wr_o 0.
- Reset asserted mid-transaction: everything returns to IDLE immediately. ram_wr_o drops asynchronously, no done is issued, and the partial data is discarded.
- Read latency: request accepted at edge E0; RD occupies cycles E0..E5 (5 cycles); done is high in the cycle after E5, i.e. the 6th cycle after acceptance.
- Store latency: done is high in the 5th cycle after acceptance.
- Back-to-back: a new request is accepted at the earliest one cycle after the done cycle (one IDLE cycle).
- Simultaneous if_ce_i and mem_ce_i in IDLE:
  - MEM is served first.
  - IF is accepted in the IDLE cycle after MEM's done.
  - stallreq_o stays high throughout, except in the cycle where a done covers every active request.

## Test plan
- Fetch at 0x100 with RAM[0x100..0x103] = 13 05 10 00 -> if_done_o pulses 6 cycles after acceptance, if_data_o = 0x00100513, stallreq_o = 0 in the done cycle.
- Byte store at 0x200, data 0xAABBCCDD, sel = 0010 -> exactly one ram_wr_o cycle with ram_a_o = 0x201 and ram_dout_o = 0xCC; mem_done_o pulses 5 cycles after acceptance.
- Word store, sel = 1111, at 0x300 with 0x12345678, then load from 0x300 -> four writes 78 56 34 12 at 0x300..0x303; mem_data_o = 0x12345678.
- if_ce_i and mem_ce_i raised together (load at 0x10 = 0xDEADBEEF, fetch at 0x0 = 0x00000013) -> mem_done_o first; if_done_o follows one IDLE cycle plus 6 cycles later; if_data_o = 0x00000013.
- Fetch at 0x1FFFE (ADDR_W = 17) -> addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001 in order.
- rst asserted during WR with cnt = 1 -> ram_wr_o = 0 immediately, no done pulse, all outputs at reset values; a new fetch after release completes normally.
